// File: rtl/battleship_pkg.sv
// rtl/battleship_pkg.sv - scan codes, entry FSM states and player constants shared by the battleship blocks
package battleship_pkg;

    // PS/2 set-2 make codes for letters A..J
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_B = 8'h32;
    localparam logic [7:0] SC_C = 8'h21;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_G = 8'h34;
    localparam logic [7:0] SC_H = 8'h33;
    localparam logic [7:0] SC_I = 8'h43;
    localparam logic [7:0] SC_J = 8'h3B;

    // PS/2 set-2 make codes for digits '0'..'9'
    localparam logic [7:0] SC_0 = 8'h45;
    localparam logic [7:0] SC_1 = 8'h16;
    localparam logic [7:0] SC_2 = 8'h1E;
    localparam logic [7:0] SC_3 = 8'h26;
    localparam logic [7:0] SC_4 = 8'h25;
    localparam logic [7:0] SC_5 = 8'h2E;
    localparam logic [7:0] SC_6 = 8'h36;
    localparam logic [7:0] SC_7 = 8'h3D;
    localparam logic [7:0] SC_8 = 8'h3E;
    localparam logic [7:0] SC_9 = 8'h46;

    localparam logic [7:0] ENTER     = 8'h5A;
    localparam logic [7:0] BACKSPACE = 8'h66;
    localparam logic [7:0] BREAK_F0  = 8'hF0;
    localparam logic [7:0] EXT_E0    = 8'hE0;

    typedef enum logic [1:0] {
        WAIT_LETTER = 2'b00,
        WAIT_NUMBER = 2'b01,
        WAIT_ENTER  = 2'b10,
        PENDING     = 2'b11
    } entry_state_t;

    localparam logic PLAYER_ONE = 1'b0;
    localparam logic PLAYER_TWO = 1'b1;

endpackage

// File: rtl/scan_decode.sv
// rtl/scan_decode.sv - combinational classifier for one PS/2 scan-code byte
//   key_data  : scan-code byte
//   is_letter : byte is A..J, code = 0..9
//   is_digit  : byte is '0'..'9', code = digit value
//   is_enter  : byte is Enter
//   is_bksp   : byte is Backspace
//   code      : letter index or digit value, 0 otherwise
module scan_decode
    import battleship_pkg::*;
(
    input  logic [7:0] key_data,
    output logic       is_letter,
    output logic       is_digit,
    output logic       is_enter,
    output logic       is_bksp,
    output logic [3:0] code
);

    always_comb begin
        is_letter = 1'b0;
        is_digit  = 1'b0;
        is_enter  = 1'b0;
        is_bksp   = 1'b0;
        code      = 4'd0;
        case (key_data)
            SC_A: begin is_letter = 1'b1; code = 4'd0; end
            SC_B: begin is_letter = 1'b1; code = 4'd1; end
            SC_C: begin is_letter = 1'b1; code = 4'd2; end
            SC_D: begin is_letter = 1'b1; code = 4'd3; end
            SC_E: begin is_letter = 1'b1; code = 4'd4; end
            SC_F: begin is_letter = 1'b1; code = 4'd5; end
            SC_G: begin is_letter = 1'b1; code = 4'd6; end
            SC_H: begin is_letter = 1'b1; code = 4'd7; end
            SC_I: begin is_letter = 1'b1; code = 4'd8; end
            SC_J: begin is_letter = 1'b1; code = 4'd9; end
            SC_0: begin is_digit  = 1'b1; code = 4'd0; end
            SC_1: begin is_digit  = 1'b1; code = 4'd1; end
            SC_2: begin is_digit  = 1'b1; code = 4'd2; end
            SC_3: begin is_digit  = 1'b1; code = 4'd3; end
            SC_4: begin is_digit  = 1'b1; code = 4'd4; end
            SC_5: begin is_digit  = 1'b1; code = 4'd5; end
            SC_6: begin is_digit  = 1'b1; code = 4'd6; end
            SC_7: begin is_digit  = 1'b1; code = 4'd7; end
            SC_8: begin is_digit  = 1'b1; code = 4'd8; end
            SC_9: begin is_digit  = 1'b1; code = 4'd9; end
            ENTER:     is_enter = 1'b1;
            BACKSPACE: is_bksp  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/shot_entry_parser.sv
// rtl/shot_entry_parser.sv - assembles letter/digit/Enter key sequences into acknowledged shot commands
//   clock27, reset         : clock, synchronous active-high reset
//   key_valid, key_data    : scan-code byte strobe from the keyboard receiver
//   shot_ack               : downstream consumed the pending shot
//   letter, number         : held shot coordinates
//   shot_valid             : shot pending until acknowledged
//   player_turn            : whose turn it is, toggles once per acknowledged shot
//   entry_state            : current entry phase for the on-screen prompt
module shot_entry_parser
    import battleship_pkg::*;
#(
    parameter int   TIMEOUT_CYCLES = 27_000_000,
    parameter logic FIRST_PLAYER   = PLAYER_ONE
) (
    input  logic       clock27,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [7:0] key_data,
    input  logic       shot_ack,
    output logic [3:0] letter,
    output logic [3:0] number,
    output logic       shot_valid,
    output logic       player_turn,
    output logic [1:0] entry_state
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    entry_state_t  state, state_d;
    logic [3:0]    letter_d, number_d;
    logic          valid_d, turn_d;
    logic          skip_next, skip_next_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          make_code, acted;

    logic       is_letter, is_digit, is_enter, is_bksp;
    logic [3:0] code;

    scan_decode u_decode (
        .key_data  (key_data),
        .is_letter (is_letter),
        .is_digit  (is_digit),
        .is_enter  (is_enter),
        .is_bksp   (is_bksp),
        .code      (code)
    );

    // Break-prefix tracking runs in every state, including PENDING, so a
    // release that straddles the ack does not leak a phantom make code.
    always_comb begin
        skip_next_d = skip_next;
        make_code   = 1'b0;
        if (key_valid) begin
            if (skip_next)
                skip_next_d = 1'b0;
            else if (key_data == BREAK_F0)
                skip_next_d = 1'b1;
            else if (key_data != EXT_E0)
                make_code = 1'b1;
        end
    end

    always_comb begin
        state_d  = state;
        letter_d = letter;
        number_d = number;
        valid_d  = shot_valid;
        turn_d   = player_turn;
        acted    = 1'b0;
        cnt_d    = '0;
        case (state)
            WAIT_LETTER: begin
                if (make_code && is_letter) begin
                    letter_d = code;
                    state_d  = WAIT_NUMBER;
                    acted    = 1'b1;
                end
            end
            WAIT_NUMBER: begin
                if (make_code) begin
                    if (is_letter) begin
                        letter_d = code;
                        acted    = 1'b1;
                    end else if (is_digit) begin
                        number_d = code;
                        state_d  = WAIT_ENTER;
                        acted    = 1'b1;
                    end else if (is_bksp) begin
                        state_d  = WAIT_LETTER;
                        acted    = 1'b1;
                    end
                end
            end
            WAIT_ENTER: begin
                if (make_code) begin
                    if (is_enter) begin
                        state_d  = PENDING;
                        valid_d  = 1'b1;
                        acted    = 1'b1;
                    end else if (is_digit) begin
                        number_d = code;
                        acted    = 1'b1;
                    end else if (is_letter) begin
                        letter_d = code;
                        state_d  = WAIT_NUMBER;
                        acted    = 1'b1;
                    end else if (is_bksp) begin
                        state_d  = WAIT_NUMBER;
                        acted    = 1'b1;
                    end
                end
            end
            PENDING: begin
                if (shot_ack) begin
                    valid_d = 1'b0;
                    turn_d  = ~player_turn;
                    state_d = WAIT_LETTER;
                end
            end
            default: state_d = WAIT_LETTER;
        endcase

        // Idle timer only runs while a partial entry is open; a key that is
        // acted on in the same cycle as expiry takes precedence.
        if ((state == WAIT_NUMBER || state == WAIT_ENTER) && !acted) begin
            if (cnt == CNT_LAST)
                state_d = WAIT_LETTER;
            else if (cnt != '1)
                cnt_d = cnt + 1'b1;
            else
                cnt_d = cnt;
        end
    end

    always_ff @(posedge clock27) begin
        if (reset) begin
            state       <= WAIT_LETTER;
            letter      <= 4'd0;
            number      <= 4'd0;
            shot_valid  <= 1'b0;
            player_turn <= FIRST_PLAYER;
            skip_next   <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_d;
            letter      <= letter_d;
            number      <= number_d;
            shot_valid  <= valid_d;
            player_turn <= turn_d;
            skip_next   <= skip_next_d;
            cnt         <= cnt_d;
        end
    end

    assign entry_state = state;

endmodule

// File: tb/tb_shot_entry_parser.sv
// tb/tb_shot_entry_parser.sv - self-checking bench for shot_entry_parser
module tb_shot_entry_parser;

    localparam int T = 16;

    logic       clock27 = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [7:0] key_data = 8'h00;
    logic       shot_ack = 1'b0;
    logic [3:0] letter, number;
    logic       shot_valid, player_turn;
    logic [1:0] entry_state;

    int n_checks = 0;
    int n_pass   = 0;

    shot_entry_parser #(.TIMEOUT_CYCLES(T), .FIRST_PLAYER(1'b0)) dut (
        .clock27     (clock27),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_data    (key_data),
        .shot_ack    (shot_ack),
        .letter      (letter),
        .number      (number),
        .shot_valid  (shot_valid),
        .player_turn (player_turn),
        .entry_state (entry_state)
    );

    always #5 clock27 = ~clock27;

    logic [7:0] letter_tab [10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
    logic [7:0] digit_tab  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] other_tab  [4]  = '{8'h75, 8'h29, 8'h00, 8'h12};

    // Reference model: how many fields of the shot are filled (0..2, 3 = waiting for ack)
    int m_fields, m_letter, m_number, m_valid, m_turn, m_skip, m_idle;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int find(input logic [7:0] b, input logic is_letter_tab);
        for (int i = 0; i < 10; i++) begin
            if (is_letter_tab && letter_tab[i] == b) return i;
            if (!is_letter_tab && digit_tab[i] == b) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic kv, input logic [7:0] kd, input logic ack, input logic rst);
        int li, di;
        bit key, took;
        if (rst) begin
            m_fields = 0; m_letter = 0; m_number = 0; m_valid = 0;
            m_turn = 0; m_skip = 0; m_idle = 0;
            return;
        end
        key = 0;
        took = 0;
        if (kv) begin
            if (m_skip != 0) m_skip = 0;
            else if (kd == 8'hF0) m_skip = 1;
            else if (kd != 8'hE0) key = 1;
        end
        li = find(kd, 1'b1);
        di = find(kd, 1'b0);
        if (m_fields == 3) begin
            if (ack) begin
                m_valid = 0; m_turn = 1 - m_turn; m_fields = 0;
            end
            m_idle = 0;
            return;
        end
        if (key) begin
            if (m_fields == 0) begin
                if (li >= 0) begin m_letter = li; m_fields = 1; took = 1; end
            end else if (m_fields == 1) begin
                if (li >= 0)          begin m_letter = li; took = 1; end
                else if (di >= 0)     begin m_number = di; m_fields = 2; took = 1; end
                else if (kd == 8'h66) begin m_fields = 0; took = 1; end
            end else begin
                if (kd == 8'h5A)      begin m_fields = 3; m_valid = 1; took = 1; end
                else if (di >= 0)     begin m_number = di; took = 1; end
                else if (li >= 0)     begin m_letter = li; m_fields = 1; took = 1; end
                else if (kd == 8'h66) begin m_fields = 1; took = 1; end
            end
        end
        if (took) begin
            m_idle = 0;
        end else if (m_fields == 1 || m_fields == 2) begin
            // The T-th consecutive idle cycle of an open entry abandons it
            if (m_idle == T - 1) begin
                m_fields = 0; m_idle = 0;
            end else begin
                m_idle++;
            end
        end else begin
            m_idle = 0;
        end
    endtask

    task automatic step(input logic kv, input logic [7:0] kd, input logic ack, input logic rst);
        @(negedge clock27);
        key_valid = kv; key_data = kd; shot_ack = ack; reset = rst;
        @(posedge clock27);
        model_step(kv, kd, ack, rst);
        #1;
        check("m_state", 32'(entry_state), 32'(m_fields));
        check("m_letter", 32'(letter), 32'(m_letter));
        check("m_number", 32'(number), 32'(m_number));
        check("m_valid", 32'(shot_valid), 32'(m_valid));
        check("m_turn", 32'(player_turn), 32'(m_turn));
    endtask

    task automatic key(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic ack(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        int r, b;
        logic [7:0] kb;

        // Reset state
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("rst_state", 32'(entry_state), 0);
        check("rst_valid", 32'(shot_valid), 0);
        check("rst_turn", 32'(player_turn), 0);
        check("rst_letter", 32'(letter), 0);
        idle(2);

        // Basic shot E8 with break codes interleaved
        key(8'h24); key(8'hF0); key(8'h24); key(8'h3E); key(8'hF0); key(8'h3E);
        key(8'h5A);
        check("basic_valid_n1", 32'(shot_valid), 1);
        key(8'hF0); key(8'h5A);
        check("basic_letter", 32'(letter), 4);
        check("basic_number", 32'(number), 8);
        check("basic_state", 32'(entry_state), 3);
        ack(1);
        check("ack_valid", 32'(shot_valid), 0);
        check("ack_turn", 32'(player_turn), 1);
        check("ack_state", 32'(entry_state), 0);
        ack(2);
        check("ack_once", 32'(player_turn), 1);

        // Row 10 and edits
        key(8'h1C); key(8'h45); key(8'h32);
        check("edit_back_num", 32'(entry_state), 1);
        key(8'h46);
        check("edit_num9", 32'(number), 9);
        key(8'h66);
        check("edit_bksp", 32'(entry_state), 1);
        key(8'h16); key(8'h5A);
        check("edit_letter", 32'(letter), 1);
        check("edit_number", 32'(number), 1);
        ack(1);
        key(8'h1C); key(8'h45); key(8'h5A);
        check("row10_number", 32'(number), 0);
        check("row10_letter", 32'(letter), 0);
        ack(1);

        // Break and extended-prefix filtering
        key(8'hF0); key(8'h1C);
        check("brk_skip", 32'(entry_state), 0);
        key(8'h1C);
        check("brk_take", 32'(entry_state), 1);
        key(8'hE0); key(8'h75);
        check("ext_ignored", 32'(entry_state), 1);

        // PENDING lockout
        key(8'h3E); key(8'h5A);
        key(8'h2B); key(8'h16); key(8'h5A);
        check("lock_letter", 32'(letter), 0);
        check("lock_number", 32'(number), 8);
        check("lock_valid", 32'(shot_valid), 1);
        ack(1);
        key(8'h2B);
        check("after_ack_state", 32'(entry_state), 1);
        check("after_ack_letter", 32'(letter), 5);

        // Timeout: 15 idle cycles keep the entry, the 16th drops it
        key(8'h21);
        for (int i = 1; i <= 15; i++) begin
            idle(1);
            check("to_hold", 32'(entry_state), 1);
        end
        idle(1);
        check("to_expire", 32'(entry_state), 0);

        // Key on the 15th cycle restarts the idle count
        key(8'h21);
        idle(14);
        key(8'h32);
        check("to_key_state", 32'(entry_state), 1);
        idle(15);
        check("to_restart_hold", 32'(entry_state), 1);
        idle(1);
        check("to_restart_expire", 32'(entry_state), 0);

        // Reset while PENDING with player two on turn
        key(8'h3B); key(8'h25); key(8'h5A); ack(1);
        key(8'h43); key(8'h36); key(8'h5A);
        check("pre_rst_turn", 32'(player_turn), 1);
        check("pre_rst_valid", 32'(shot_valid), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("mid_rst_valid", 32'(shot_valid), 0);
        check("mid_rst_turn", 32'(player_turn), 0);
        check("mid_rst_state", 32'(entry_state), 0);
        check("mid_rst_letter", 32'(letter), 0);
        check("mid_rst_number", 32'(number), 0);
        idle(1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                idle(20);
            end else begin
                r = $urandom_range(0, 99);
                b = $urandom_range(0, 99);
                if (b < 40)      kb = letter_tab[$urandom_range(0, 9)];
                else if (b < 70) kb = digit_tab[$urandom_range(0, 9)];
                else if (b < 80) kb = 8'h5A;
                else if (b < 85) kb = 8'h66;
                else if (b < 92) kb = 8'hF0;
                else if (b < 95) kb = 8'hE0;
                else             kb = other_tab[$urandom_range(0, 3)];
                step(r < 60, kb, $urandom_range(0, 99) < 15, $urandom_range(0, 999) < 5);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
